// File: rtl/branch_pc_unit_pkg.sv
// Shared miniRISC definitions: branch opcodes seen by the decoder and the PC unit state set.
// Also holds the sequential-PC helper used wherever pc+step is formed.
package branch_pc_unit_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [3:0] {
      BrNone = 4'd0,
      BrBr   = 4'd1,
      BrBltz = 4'd2,
      BrBz   = 4'd3,
      BrBnz  = 4'd4,
      BrB    = 4'd5,
      BrBl   = 4'd6,
      BrBcy  = 4'd7,
      BrBncy = 4'd8,
      BrHalt = 4'd9
   } br_op_e;

   typedef enum logic {
      StRun    = 1'b0,
      StHalted = 1'b1
   } pc_state_e;

   function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc,
                                              input logic [XLEN-1:0] step);
      return pc + step;
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: decides whether the current br_op redirects the PC.
// Purely combinational; unknown and non-branch opcodes never take.
module branch_cond
   import branch_pc_unit_pkg::*;
(
   input  logic [3:0] br_op,
   input  logic       alu_sign,
   input  logic       alu_zero,
   input  logic       carry_flag,
   output logic       take
);

   always_comb begin
      take = 1'b0;
      case (br_op)
         BrBr, BrB, BrBl: take = 1'b1;
         BrBltz:          take = alu_sign;
         BrBz:            take = alu_zero;
         BrBnz:           take = ~alu_zero;
         BrBcy:           take = carry_flag;
         BrBncy:          take = ~carry_flag;
         default:         take = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter and branch resolution for miniRISC: sequential advance, redirects,
// BL link capture, carry flag and the RUN/HALTED state. All outputs come from flops.
module branch_pc_unit
   import branch_pc_unit_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'd0,
   parameter logic [31:0] PC_STEP  = 32'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [3:0]  br_op,
   input  logic [31:0] alu_result,
   input  logic        alu_sign,
   input  logic        alu_zero,
   input  logic        alu_carry,
   input  logic        carry_we,
   input  logic [31:0] offset,
   output logic [31:0] pc,
   output logic [31:0] link_addr,
   output logic        link_we,
   output logic        taken,
   output logic        flush,
   output logic        carry_flag,
   output logic        halted
);

   pc_state_e   state_q;
   logic [31:0] pc_q;
   logic [31:0] link_addr_q;
   logic        carry_q;
   logic        link_we_q;
   logic        taken_q;

   logic        br_take;
   logic        is_bl;
   logic        is_halt;
   logic        advance;
   logic [31:0] pc_seq;
   logic [31:0] pc_tgt;

   branch_cond u_branch_cond (
      .br_op      (br_op),
      .alu_sign   (alu_sign),
      .alu_zero   (alu_zero),
      .carry_flag (carry_q),
      .take       (br_take)
   );

   always_comb begin
      is_bl   = (br_op == BrBl);
      is_halt = (br_op == BrHalt);
      advance = en && (state_q == StRun);
      pc_seq  = seq_pc(pc_q, PC_STEP);
      pc_tgt  = (br_op == BrBr) ? alu_result : (pc_seq + offset);
   end

   // carry_q feeds branch_cond before this edge, so a same-cycle carry_we only affects later BCY/BNCY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         pc_q        <= PC_RESET;
         link_addr_q <= 32'd0;
         carry_q     <= 1'b0;
         link_we_q   <= 1'b0;
         taken_q     <= 1'b0;
      end else begin
         link_we_q <= 1'b0;
         taken_q   <= 1'b0;
         if (advance) begin
            taken_q   <= br_take;
            link_we_q <= is_bl;
            if (carry_we) begin
               carry_q <= alu_carry;
            end
            if (is_bl) begin
               link_addr_q <= pc_seq;
            end
            // HALT parks the PC on the halting instruction.
            if (is_halt) begin
               state_q <= StHalted;
            end else begin
               pc_q <= br_take ? pc_tgt : pc_seq;
            end
         end
      end
   end

   assign pc         = pc_q;
   assign link_addr  = link_addr_q;
   assign link_we    = link_we_q;
   assign taken      = taken_q;
   assign flush      = taken_q;
   assign carry_flag = carry_q;
   assign halted     = (state_q == StHalted);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed vector table, halt/reset sequence,
// then randomized traffic against a behavioural model.
module tb_branch_pc_unit;
   import branch_pc_unit_pkg::*;

   localparam logic [31:0] PcReset = 32'd0;
   localparam logic [31:0] PcStep  = 32'd1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [3:0]  br_op;
   logic [31:0] alu_result;
   logic        alu_sign;
   logic        alu_zero;
   logic        alu_carry;
   logic        carry_we;
   logic [31:0] offset;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic        link_we;
   logic        taken;
   logic        flush;
   logic        carry_flag;
   logic        halted;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_pc_unit #(
      .PC_RESET (PcReset),
      .PC_STEP  (PcStep)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .br_op      (br_op),
      .alu_result (alu_result),
      .alu_sign   (alu_sign),
      .alu_zero   (alu_zero),
      .alu_carry  (alu_carry),
      .carry_we   (carry_we),
      .offset     (offset),
      .pc         (pc),
      .link_addr  (link_addr),
      .link_we    (link_we),
      .taken      (taken),
      .flush      (flush),
      .carry_flag (carry_flag),
      .halted     (halted)
   );

   typedef struct {
      logic        en;
      logic [3:0]  op;
      logic [31:0] ar;
      logic        sign;
      logic        zero;
      logic        carry;
      logic        cwe;
      logic [31:0] off;
      logic [31:0] e_pc;
      logic        e_taken;
      logic        e_lw;
      logic [31:0] e_link;
      logic        e_carry;
   } vec_t;

   vec_t vq[$];

   // Behavioural model state
   logic [31:0] m_pc;
   logic [31:0] m_link;
   logic        m_carry;
   logic        m_halted;
   logic        m_taken;
   logic        m_lw;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic e, input logic [3:0] op, input logic [31:0] ar,
                               input logic sg, input logic zr, input logic cy, input logic cwe,
                               input logic [31:0] off, input logic [31:0] e_pc,
                               input logic e_t, input logic e_lw, input logic [31:0] e_link,
                               input logic e_c);
      vec_t v;
      v.en = e; v.op = op; v.ar = ar; v.sign = sg; v.zero = zr; v.carry = cy; v.cwe = cwe;
      v.off = off; v.e_pc = e_pc; v.e_taken = e_t; v.e_lw = e_lw; v.e_link = e_link;
      v.e_carry = e_c;
      vq.push_back(v);
   endfunction

   task automatic drive(input logic e, input logic [3:0] op, input logic [31:0] ar,
                        input logic sg, input logic zr, input logic cy, input logic cwe,
                        input logic [31:0] off);
      en = e; br_op = op; alu_result = ar; alu_sign = sg; alu_zero = zr;
      alu_carry = cy; carry_we = cwe; offset = off;
   endtask

   task automatic model_reset();
      m_pc = PcReset; m_link = 32'd0; m_carry = 1'b0; m_halted = 1'b0;
      m_taken = 1'b0; m_lw = 1'b0;
   endtask

   // Applies the instruction rules to the inputs currently presented.
   task automatic model_step();
      bit cond;
      logic [31:0] nxt;
      m_taken = 1'b0;
      m_lw    = 1'b0;
      if (en && !m_halted) begin
         case (int'(br_op))
            1, 5, 6: cond = 1;
            2:       cond = alu_sign;
            3:       cond = alu_zero;
            4:       cond = !alu_zero;
            7:       cond = m_carry;
            8:       cond = !m_carry;
            default: cond = 0;
         endcase
         nxt = m_pc + PcStep;
         if (int'(br_op) == 6) m_link = m_pc + PcStep;
         if (int'(br_op) == 9) m_halted = 1'b1;
         else if (cond && int'(br_op) == 1) nxt = alu_result;
         else if (cond) nxt = m_pc + PcStep + offset;
         if (int'(br_op) != 9) m_pc = nxt;
         if (carry_we) m_carry = alu_carry;
         m_taken = cond;
         m_lw    = (int'(br_op) == 6);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".link_addr"}, link_addr, m_link);
      check({tag, ".link_we"}, {31'd0, link_we}, {31'd0, m_lw});
      check({tag, ".taken"}, {31'd0, taken}, {31'd0, m_taken});
      check({tag, ".flush"}, {31'd0, flush}, {31'd0, m_taken});
      check({tag, ".carry_flag"}, {31'd0, carry_flag}, {31'd0, m_carry});
      check({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  rop;
      logic [31:0] roff;

      rst_n = 1'b0;
      drive(1'b0, BrNone, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_model("reset");

      // en op ar sign zero carry cwe offset | pc taken link_we link carry
      add(1'b1, BrNone, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'd1,  1'b0, 1'b0, 32'd0, 1'b0);
      add(1'b1, BrNone, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'd2,  1'b0, 1'b0, 32'd0, 1'b0);
      add(1'b1, BrNone, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'd3,  1'b0, 1'b0, 32'd0, 1'b0);
      add(1'b1, BrBr,   32'd10, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'd10, 1'b1, 1'b0, 32'd0, 1'b0);
      add(1'b1, BrB,    32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFB,
          32'd6, 1'b1, 1'b0, 32'd0, 1'b0);
      add(1'b1, BrNone, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'd7,  1'b0, 1'b0, 32'd0, 1'b0);
      add(1'b1, BrBl,   32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd3,  32'd11, 1'b1, 1'b1, 32'd8, 1'b0);
      add(1'b1, BrBr,   32'd8,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'd8,  1'b1, 1'b0, 32'd8, 1'b0);
      // Carry from 0xFFFFFFFF + 1392 captured alongside the jump to 20
      add(1'b1, BrBr,   32'd20, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0,  32'd20, 1'b1, 1'b0, 32'd8, 1'b1);
      add(1'b1, BrBcy,  32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd4,  32'd25, 1'b1, 1'b0, 32'd8, 1'b1);
      add(1'b1, BrBr,   32'd20, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'd20, 1'b1, 1'b0, 32'd8, 1'b1);
      add(1'b1, BrBncy, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd4,  32'd21, 1'b0, 1'b0, 32'd8, 1'b1);
      add(1'b0, BrBz,   32'd0,  1'b0, 1'b1, 1'b0, 1'b1, 32'd2,  32'd21, 1'b0, 1'b0, 32'd8, 1'b1);
      add(1'b0, BrBz,   32'd0,  1'b0, 1'b1, 1'b0, 1'b1, 32'd2,  32'd21, 1'b0, 1'b0, 32'd8, 1'b1);
      add(1'b1, BrBz,   32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'd2,  32'd24, 1'b1, 1'b0, 32'd8, 1'b1);
      add(1'b1, BrBcy,  32'd0,  1'b0, 1'b0, 1'b0, 1'b1, 32'd4,  32'd29, 1'b1, 1'b0, 32'd8, 1'b0);
      add(1'b1, BrBncy, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd1,  32'd31, 1'b1, 1'b0, 32'd8, 1'b0);
      add(1'b1, BrBltz, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'd16, 32'd48, 1'b1, 1'b0, 32'd8, 1'b0);
      add(1'b1, BrBltz, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd16, 32'd49, 1'b0, 1'b0, 32'd8, 1'b0);
      add(1'b1, BrBnz,  32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFCF,
          32'd1, 1'b1, 1'b0, 32'd8, 1'b0);
      add(1'b1, 4'd12,  32'd99, 1'b1, 1'b1, 1'b0, 1'b0, 32'd7,  32'd2,  1'b0, 1'b0, 32'd8, 1'b0);
      add(1'b1, BrBr,   32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,
          32'hFFFF_FFFF, 1'b1, 1'b0, 32'd8, 1'b0);
      add(1'b1, BrNone, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'd0,  1'b0, 1'b0, 32'd8, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      foreach (vq[i]) begin
         drive(vq[i].en, vq[i].op, vq[i].ar, vq[i].sign, vq[i].zero, vq[i].carry,
               vq[i].cwe, vq[i].off);
         tick();
         check($sformatf("vec%0d.pc", i), pc, vq[i].e_pc);
         check($sformatf("vec%0d.taken", i), {31'd0, taken}, {31'd0, vq[i].e_taken});
         check($sformatf("vec%0d.flush", i), {31'd0, flush}, {31'd0, vq[i].e_taken});
         check($sformatf("vec%0d.link_we", i), {31'd0, link_we}, {31'd0, vq[i].e_lw});
         check($sformatf("vec%0d.link_addr", i), link_addr, vq[i].e_link);
         check($sformatf("vec%0d.carry", i), {31'd0, carry_flag}, {31'd0, vq[i].e_carry});
      end

      // HALT at pc=5 freezes everything until an asynchronous reset
      drive(1'b1, BrBr, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      check("halt.setup_pc", pc, 32'd5);
      drive(1'b1, BrHalt, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      check("halt.enter_pc", pc, 32'd5);
      check("halt.enter_halted", {31'd0, halted}, 32'd1);
      check("halt.enter_taken", {31'd0, taken}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, BrB, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd9);
         tick();
         check($sformatf("halt%0d.pc", i), pc, 32'd5);
         check($sformatf("halt%0d.halted", i), {31'd0, halted}, 32'd1);
         check($sformatf("halt%0d.taken", i), {31'd0, taken}, 32'd0);
         check($sformatf("halt%0d.carry", i), {31'd0, carry_flag}, 32'd0);
      end
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst.pc", pc, PcReset);
      check("async_rst.halted", {31'd0, halted}, 32'd0);
      check("async_rst.link_addr", link_addr, 32'd0);
      check("async_rst.taken", {31'd0, taken}, 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive(1'b1, BrNone, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      check_model("first_adv");

      // Randomized traffic; HALT excluded so the run keeps exercising branches
      for (int i = 0; i < 400; i++) begin
         rop  = 4'($urandom_range(0, 15));
         if (rop == 4'd9) rop = BrBl;
         roff = 32'($urandom_range(0, 63)) - 32'd32;
         drive(($urandom_range(0, 3) != 0), rop, $urandom, 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), roff);
         tick();
         check_model($sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
